// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM encoding and default geometry for the banked cache line store.
//   ST_INIT/ST_IDLE/ST_FILL : controller states
//   *_DEF                   : default BANK_NUM / DATA_WIDTH / INDEX_AW
package cache_pkg;
  localparam int BANK_NUM_DEF = 4;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int INDEX_AW_DEF = 8;
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;
endpackage

// File: rtl/simple_dp_ram.sv
// simple_dp_ram: one-write one-read synchronous RAM with registered read data.
//   clk, rst_n         : clock, async active-low reset (read register only)
//   we, waddr, wdata   : write port
//   re, raddr, rdata   : read port, rdata updates the cycle after re and holds otherwise
module simple_dp_ram #(
  parameter int WIDTH = 8,
  parameter int AW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/cache_line_banks.sv
// cache_line_banks: banked cache line store with zeroing sweep, byte-enable writes and line refill.
//   clk, rst_n                       : clock, async active-low reset
//   req_ready_o                      : high in IDLE; rd/wr/fill_start accepted only then
//   index_i, rd_req_i                : full-line read, data one cycle later on rd_line_o/rd_valid_o
//   wr_req_i, wr_bank_i, wr_be_i,
//   wr_data_i                        : byte-enabled write of one bank word at index_i
//   fill_start_i, fill_index_i       : start a refill of fill_index_i (wins over rd/wr)
//   fill_valid_i, fill_data_i,
//   fill_ready_o, fill_done_o        : refill beats, bank 0 first; done pulses after last beat
module cache_line_banks import cache_pkg::*; #(
  parameter int BANK_NUM = BANK_NUM_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int INDEX_AW = INDEX_AW_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  output logic                           req_ready_o,
  input  logic [INDEX_AW-1:0]            index_i,
  input  logic                           rd_req_i,
  input  logic                           wr_req_i,
  input  logic [$clog2(BANK_NUM)-1:0]    wr_bank_i,
  input  logic [DATA_WIDTH/8-1:0]        wr_be_i,
  input  logic [DATA_WIDTH-1:0]          wr_data_i,
  input  logic                           fill_start_i,
  input  logic [INDEX_AW-1:0]            fill_index_i,
  input  logic                           fill_valid_i,
  input  logic [DATA_WIDTH-1:0]          fill_data_i,
  output logic                           fill_ready_o,
  output logic                           fill_done_o,
  output logic                           rd_valid_o,
  output logic [BANK_NUM*DATA_WIDTH-1:0] rd_line_o
);
  localparam int BW = $clog2(BANK_NUM);
  localparam int LANES = DATA_WIDTH / 8;
  logic [1:0] state;
  logic [INDEX_AW-1:0] init_cnt, fill_idx, waddr;
  logic [BW-1:0] beat_cnt;
  logic [BANK_NUM*LANES-1:0] lane_wr, byp_mask;
  logic [DATA_WIDTH-1:0] byp_data;
  logic init_we, fill_acc, rd_acc, wr_acc, beat, last_beat;
  assign req_ready_o = state == ST_IDLE;
  assign fill_ready_o = state == ST_FILL;
  assign init_we = state == ST_INIT;
  assign fill_acc = req_ready_o && fill_start_i;
  assign rd_acc = req_ready_o && rd_req_i && !fill_start_i;
  assign wr_acc = req_ready_o && wr_req_i && !fill_start_i;
  assign beat = fill_ready_o && fill_valid_i;
  assign last_beat = beat && beat_cnt == BW'(BANK_NUM - 1);
  assign waddr = init_we ? init_cnt : fill_ready_o ? fill_idx : index_i;
  for (genvar k = 0; k < BANK_NUM; k++) begin : g_bank
    for (genvar b = 0; b < LANES; b++) begin : g_lane
      logic [7:0] q;
      assign lane_wr[k*LANES+b] = wr_acc && wr_bank_i == BW'(k) && wr_be_i[b];
      simple_dp_ram #(.WIDTH(8), .AW(INDEX_AW)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (init_we || lane_wr[k*LANES+b] || (beat && beat_cnt == BW'(k))),
        .waddr (waddr),
        .wdata (init_we ? 8'h00 : fill_ready_o ? fill_data_i[b*8 +: 8] : wr_data_i[b*8 +: 8]),
        .re    (rd_acc),
        .raddr (index_i),
        .rdata (q)
      );
      // Bytes written in the same cycle as the read come from the bypass register, not the RAM.
      assign rd_line_o[(k*LANES+b)*8 +: 8] = byp_mask[k*LANES+b] ? byp_data[b*8 +: 8] : q;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_INIT;
      init_cnt <= '0;
      beat_cnt <= '0;
      fill_idx <= '0;
      fill_done_o <= 1'b0;
      rd_valid_o <= 1'b0;
      byp_mask <= '0;
      byp_data <= '0;
    end else begin
      state <= (init_we && &init_cnt) || last_beat ? ST_IDLE : fill_acc ? ST_FILL : state;
      init_cnt <= init_we ? init_cnt + 1'b1 : init_cnt;
      fill_done_o <= last_beat;
      rd_valid_o <= rd_acc;
      if (fill_acc) fill_idx <= fill_index_i;
      if (beat) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      // Bypass state only changes on an accepted read so rd_line_o holds between reads.
      if (rd_acc) begin
        byp_mask <= lane_wr;
        byp_data <= wr_data_i;
      end
    end
endmodule

// File: tb/tb_cache_line_banks.sv
// tb_cache_line_banks: randomized self-checking bench for cache_line_banks against a line-array model.
module tb_cache_line_banks;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_ready, rd_req, wr_req, fill_start, fill_valid, fill_ready, fill_done, rd_valid;
  logic [7:0] index, fill_index;
  logic [1:0] wr_bank;
  logic [3:0] wr_be;
  logic [31:0] wr_data, fill_data;
  logic [127:0] rd_line, last_line;
  logic [31:0] mem [256][4];
  int nvec = 0, nerr = 0;

  cache_line_banks dut (
    .clk(clk), .rst_n(rst_n), .req_ready_o(req_ready), .index_i(index),
    .rd_req_i(rd_req), .wr_req_i(wr_req), .wr_bank_i(wr_bank), .wr_be_i(wr_be),
    .wr_data_i(wr_data), .fill_start_i(fill_start), .fill_index_i(fill_index),
    .fill_valid_i(fill_valid), .fill_data_i(fill_data), .fill_ready_o(fill_ready),
    .fill_done_o(fill_done), .rd_valid_o(rd_valid), .rd_line_o(rd_line)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rd_req = 0; wr_req = 0; fill_start = 0; fill_valid = 0;
  endtask

  function automatic logic [127:0] line_of(input int idx);
    return {mem[idx][3], mem[idx][2], mem[idx][1], mem[idx][0]};
  endfunction

  task automatic model_wr(input int idx, input int bank, input logic [3:0] be, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (be[b]) mem[idx][bank][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic wait_init();
    int cnt = 0;
    while (!req_ready && cnt < 1000) begin
      step();
      cnt++;
    end
    check("init_len", cnt, 256);
    for (int i = 0; i < 256; i++)
      for (int k = 0; k < 4; k++) mem[i][k] = 0;
  endtask

  task automatic do_write(input int idx, input int bank, input logic [3:0] be, input logic [31:0] d);
    index = idx[7:0]; wr_req = 1; wr_bank = bank[1:0]; wr_be = be; wr_data = d;
    fill_valid = $urandom_range(0, 1);
    fill_data = $urandom;
    step();
    quiet();
    model_wr(idx, bank, be, d);
    check("wr_no_rd_valid", rd_valid, 0);
  endtask

  task automatic do_read(input int idx, input bit with_wr, input int bank, input logic [3:0] be, input logic [31:0] d);
    index = idx[7:0]; rd_req = 1; wr_req = with_wr; wr_bank = bank[1:0]; wr_be = be; wr_data = d;
    if (with_wr) model_wr(idx, bank, be, d);
    last_line = line_of(idx);
    step();
    quiet();
    check("rd_valid", rd_valid, 1);
    check("rd_line", rd_line, last_line);
  endtask

  task automatic hold_check();
    step();
    check("hold_valid", rd_valid, 0);
    check("hold_line", rd_line, last_line);
  endtask

  task automatic do_fill(input int idx, input logic [127:0] beats, input bit stall, input bit with_wr);
    int dones = 0;
    logic [127:0] other;
    other = line_of(idx ^ 1);
    fill_start = 1; fill_index = idx[7:0];
    if (with_wr) begin
      wr_req = 1; rd_req = 1; index = idx[7:0] ^ 8'h01; wr_bank = 1; wr_be = 4'hf; wr_data = ~beats[31:0];
    end
    step();
    quiet();
    check("fill_ready", fill_ready, 1);
    check("fill_req_ready", req_ready, 0);
    if (with_wr) check("fill_rd_dropped", rd_valid, 0);
    for (int k = 0; k < 4; k++) begin
      if (stall && k == 2)
        repeat (2) begin
          rd_req = 1; wr_req = 1; index = idx[7:0]; wr_bank = 2; wr_be = 4'hf; wr_data = 32'hdead_beef;
          step();
          quiet();
          dones += int'(fill_done);
          check("stall_rd_ignored", rd_valid, 0);
          check("stall_ready", fill_ready, 1);
        end
      fill_valid = 1; fill_data = beats[k*32 +: 32];
      step();
      fill_valid = 0;
      dones += int'(fill_done);
      if (k < 3) check("beat_ready", fill_ready, 1);
    end
    check("done_pulse", fill_done, 1);
    check("ready_at_done", req_ready, 1);
    check("fill_not_ready", fill_ready, 0);
    step();
    check("done_once", fill_done, 0);
    check("done_count", dones, 1);
    for (int k = 0; k < 4; k++) mem[idx][k] = beats[k*32 +: 32];
    if (with_wr) begin
      do_read(idx ^ 1, 0, 0, 0, 0);
      check("fill_wr_dropped", rd_line, other);
    end
  endtask

  initial begin
    logic [127:0] beats;
    quiet();
    index = 0; fill_index = 0; wr_bank = 0; wr_be = 0; wr_data = 0; fill_data = 0; last_line = 0;
    repeat (3) step();
    check("rst_req_ready", req_ready, 0);
    check("rst_fill_ready", fill_ready, 0);
    check("rst_fill_done", fill_done, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_line", rd_line, 0);
    rst_n = 1;
    wait_init();
    for (int i = 0; i < 256; i++) do_read(i, 0, 0, 0, 0);
    hold_check();

    do_write(8'h12, 2, 4'b0101, 32'hAABBCCDD);
    do_read(8'h12, 0, 0, 0, 0);
    check("wr_bank2_exact", rd_line, {32'h0, 32'h00BB00DD, 64'h0});
    do_read(8'h05, 1, 0, 4'b1111, 32'h11223344);
    check("rdwr_bank0_exact", rd_line[31:0], 32'h11223344);
    hold_check();
    do_write(8'h07, 3, 4'b1001, 32'h12345678);
    do_read(8'h07, 1, 3, 4'b0110, 32'h9ABCDEF0);
    check("merge_exact", rd_line[127:96], 32'h12BCDE78);

    do_fill(8'h40, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1, 0);
    do_read(8'h40, 0, 0, 0, 0);
    check("fill_exact", rd_line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    do_fill(8'h22, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 0, 1);
    do_read(8'h22, 0, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      int op, idx, bank;
      op = $urandom_range(0, 9);
      idx = $urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 15);
      bank = $urandom_range(0, 3);
      if (op < 4) begin
        do_read(idx, 0, 0, 0, 0);
        if (op == 0) hold_check();
      end else if (op < 7) do_write(idx, bank, 4'($urandom), $urandom);
      else if (op < 9) do_read(idx, 1, bank, 4'($urandom), $urandom);
      else begin
        beats = {$urandom, $urandom, $urandom, $urandom};
        do_fill(idx, beats, 1'($urandom), 1'($urandom));
      end
    end

    fill_start = 1; fill_index = 8'h40;
    step();
    quiet();
    for (int k = 0; k < 2; k++) begin
      fill_valid = 1; fill_data = 32'hC0 + k;
      step();
    end
    quiet();
    rst_n = 0;
    #1;
    check("midrst_fill_ready", fill_ready, 0);
    check("midrst_req_ready", req_ready, 0);
    check("midrst_rd_line", rd_line, 0);
    repeat (2) step();
    rst_n = 1;
    wait_init();
    do_read(8'h40, 0, 0, 0, 0);
    check("midrst_line_zero", rd_line, 0);
    do_read(8'h12, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
